// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch slice.
//
// Contents:
//    InstrBytes     - size of one instruction in bytes (PC step)
//    DefaultWidth   - default address / instruction width
//    addr_t         - byte address at the default width
//    instr_t        - instruction word at the default width
//    fetch_entry_t  - one buffered fetch: {pc, instr}
//    alignPc()      - clears the two low address bits of a jump target
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int InstrBytes   = 4;
   localparam int DefaultWidth = 32;

   typedef logic [DefaultWidth-1:0] addr_t;
   typedef logic [DefaultWidth-1:0] instr_t;

   typedef struct packed {
      addr_t  pc;
      instr_t instr;
   } fetch_entry_t;

   // Instructions are word aligned, so a jump target never carries
   // meaningful information in its two lowest bits.
   function automatic addr_t alignPc(input addr_t target);
      return {target[DefaultWidth-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
// Small synchronous FIFO holding fetched {pc, instr} entries between the
// instruction memory and decode. A flush empties it in one cycle by
// clearing the pointers; the storage itself is never cleared.
//
// Parameters:
//    Depth    - number of entries, power of two, at least 2
//    entry_t  - type of one stored entry
//
// Ports:
//    clk          in   clock
//    rst          in   synchronous active-high reset
//    i_flush      in   discard all entries this cycle (wins over push/pop)
//    i_push       in   write i_pushData at the tail
//    i_pushData   in   entry to write
//    i_pop        in   advance the head
//    o_headData   out  entry at the head (meaningless when empty)
//    o_count      out  number of valid entries
//    o_full       out  count == Depth
//    o_empty      out  count == 0
// ----------------------------------------------------------------------------
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int  Depth   = 2,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  entry_t                     i_pushData,
   input  logic                       i_pop,
   output entry_t                     o_headData,
   output logic [$clog2(Depth):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PtrW = $clog2(Depth) + 1;
   localparam int IdxW = PtrW - 1;
   localparam logic [PtrW-1:0] DepthCount = PtrW'(Depth);

   entry_t            r_mem [Depth];
   logic [PtrW-1:0]   r_rdPtr;
   logic [PtrW-1:0]   r_wrPtr;
   logic [PtrW-1:0]   r_count;

   logic [IdxW-1:0]   w_rdIdx;
   logic [IdxW-1:0]   w_wrIdx;
   logic              w_doPush;
   logic              w_doPop;

   assign w_rdIdx = r_rdPtr[IdxW-1:0];
   assign w_wrIdx = r_wrPtr[IdxW-1:0];

   // The caller is trusted to push only when there is room (or a pop frees
   // one in the same cycle) and to pop only when non-empty; the guards here
   // keep the pointers consistent even if that contract is broken.
   assign w_doPush = i_push && (!o_full || i_pop);
   assign w_doPop  = i_pop && !o_empty;

   // Pointer and occupancy bookkeeping. Reset and flush both drop every
   // entry by rewinding the pointers; a simultaneous push+pop leaves the
   // count unchanged.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PtrW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PtrW'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + PtrW'(1);
            2'b01:   r_count <= r_count - PtrW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage has no reset: only the pointers decide what is valid,
   // so stale contents are harmless and cost no reset wiring.
   always_ff @(posedge clk) begin
      if (!rst && !i_flush && w_doPush) begin
         r_mem[w_wrIdx] <= i_pushData;
      end
   end

   assign o_headData = r_mem[w_rdIdx];
   assign o_count    = r_count;
   assign o_full     = (r_count == DepthCount);
   assign o_empty    = (r_count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch-side initiator for the instruction memory. Owns the program
// counter, issues one fetch per cycle while the buffer has room, and hands
// buffered instructions to decode over a valid/ready handshake. A redirect
// from execute flushes the buffer and restarts fetch at the new target.
//
// Parameters:
//    Width        - address and instruction width
//    ResetVector  - PC loaded on reset
//    Depth        - buffer entries, power of two, at least 2
//
// Ports:
//    clk             in   clock
//    rst             in   synchronous active-high reset
//    imem_address    out  byte address of the fetch (always the current PC)
//    imem_valid      out  fetch request this cycle
//    imem_data       in   instruction word, returned in the same cycle
//    redirect_valid  in   flush and jump request
//    redirect_pc     in   jump target, low two bits ignored
//    out_valid       out  buffered instruction available to decode
//    out_ready       in   decode accepts the head instruction
//    out_instr       out  instruction at the buffer head
//    out_pc          out  PC of out_instr
// ----------------------------------------------------------------------------
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int               Width       = 32,
   parameter logic [Width-1:0] ResetVector = '0,
   parameter int               Depth       = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic [Width-1:0]  imem_address,
   output logic              imem_valid,
   input  logic [Width-1:0]  imem_data,
   input  logic              redirect_valid,
   input  logic [Width-1:0]  redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [Width-1:0]  out_instr,
   output logic [Width-1:0]  out_pc
);

   localparam int CountW = $clog2(Depth) + 1;
   localparam logic [CountW-1:0] DepthCount = CountW'(Depth);

   // Buffer entries follow this instance's Width rather than the package
   // default, so the design stays correct for non-32-bit configurations.
   typedef struct packed {
      logic [Width-1:0] pc;
      logic [Width-1:0] instr;
   } entry_t;

   logic [Width-1:0]   r_pc;

   entry_t             w_pushEntry;
   entry_t             w_headEntry;
   logic [CountW-1:0]  w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_outValid;
   logic               w_pop;
   logic               w_fetch;
   logic [Width-1:0]   w_redirectTarget;

   // Handshake and fetch enable. Redirect and reset both suppress
   // out_valid, so no pop can be counted in a cycle whose buffer contents
   // are being thrown away. A full buffer may still fetch when decode
   // drains the head in the same cycle.
   always_comb begin
      w_outValid = !rst && !redirect_valid && !w_empty;
      w_pop      = w_outValid && out_ready;
      w_fetch    = !rst && !redirect_valid && (!w_full || w_pop);
   end

   assign w_redirectTarget = {redirect_pc[Width-1:2], 2'b00};

   // Program counter. Advancing by one instruction wraps naturally at the
   // top of the address space; a stalled fetch holds the PC.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= ResetVector;
      end else if (redirect_valid) begin
         r_pc <= w_redirectTarget;
      end else if (w_fetch) begin
         r_pc <= r_pc + Width'(InstrBytes);
      end
   end

   assign w_pushEntry.pc    = r_pc;
   assign w_pushEntry.instr = imem_data;

   fetch_buffer #(
      .Depth   (Depth),
      .entry_t (entry_t)
   ) u_buffer (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (redirect_valid),
      .i_push     (w_fetch),
      .i_pushData (w_pushEntry),
      .i_pop      (w_pop),
      .o_headData (w_headEntry),
      .o_count    (w_count),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   // Occupancy can never exceed the buffer size; a violation means the
   // fetch enable let a push through with no room.
   assert property (@(posedge clk) w_count <= DepthCount);

   assign imem_address = r_pc;
   assign imem_valid   = w_fetch;
   assign out_valid    = w_outValid;
   assign out_instr    = w_headEntry.instr;
   assign out_pc       = w_headEntry.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed testbench for instruction_fetch. Memory word[i] = 0x1000 + i is
// modelled combinationally from the requested address. A second instance
// with ResetVector = 0xFFFFFFFC exercises PC wrap-around.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] imemAddress;
   logic        imemValid;
   logic [31:0] imemData;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInstr;
   logic [31:0] outPc;

   logic        rstWrap;
   logic [31:0] wrapAddress;
   logic        wrapImemValid;
   logic [31:0] wrapData;
   logic        wrapOutValid;
   logic [31:0] wrapOutInstr;
   logic [31:0] wrapOutPc;
   logic        wrapRedirect;
   logic [31:0] wrapRedirectPc;
   logic        wrapReady;

   int checkCount;
   int passCount;

   instruction_fetch #(
      .Width       (32),
      .ResetVector (32'h0),
      .Depth       (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_address   (imemAddress),
      .imem_valid     (imemValid),
      .imem_data      (imemData),
      .redirect_valid (redirectValid),
      .redirect_pc    (redirectPc),
      .out_valid      (outValid),
      .out_ready      (outReady),
      .out_instr      (outInstr),
      .out_pc         (outPc)
   );

   instruction_fetch #(
      .Width       (32),
      .ResetVector (32'hFFFF_FFFC),
      .Depth       (2)
   ) dutWrap (
      .clk            (clk),
      .rst            (rstWrap),
      .imem_address   (wrapAddress),
      .imem_valid     (wrapImemValid),
      .imem_data      (wrapData),
      .redirect_valid (wrapRedirect),
      .redirect_pc    (wrapRedirectPc),
      .out_valid      (wrapOutValid),
      .out_ready      (wrapReady),
      .out_instr      (wrapOutInstr),
      .out_pc         (wrapOutPc)
   );

   // Instruction memory model: word index = byte address / 4.
   assign imemData = 32'h1000 + (imemAddress >> 2);
   assign wrapData = 32'h1000 + (wrapAddress >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance one clock, then drive this cycle's inputs away from the edge
   // and let the combinational outputs settle before any checks.
   task automatic applyStimulus(input logic rstV, input logic readyV,
                                input logic redirV, input logic [31:0] redirPcV);
      @(posedge clk);
      #1;
      rst           = rstV;
      outReady      = readyV;
      redirectValid = redirV;
      redirectPc    = redirPcV;
      #1;
   endtask

   initial begin
      checkCount     = 0;
      passCount      = 0;
      rst            = 1'b1;
      outReady       = 1'b1;
      redirectValid  = 1'b0;
      redirectPc     = 32'h0;
      rstWrap        = 1'b1;
      wrapRedirect   = 1'b0;
      wrapRedirectPc = 32'h0;
      wrapReady      = 1'b1;

      // Reset is held: nothing requested, nothing offered.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("rst imem_valid", 32'(imemValid), 32'h0);
      checkOutput("rst out_valid",  32'(outValid),  32'h0);

      // Streaming with out_ready = 1.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("s0 imem_address", imemAddress, 32'h0);
      checkOutput("s0 imem_valid",   32'(imemValid), 32'h1);
      checkOutput("s0 out_valid",    32'(outValid),  32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("s1 imem_address", imemAddress, 32'h4);
      checkOutput("s1 out_valid",    32'(outValid), 32'h1);
      checkOutput("s1 out_pc",       outPc,    32'h0);
      checkOutput("s1 out_instr",    outInstr, 32'h1000);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("s2 imem_address", imemAddress, 32'h8);
      checkOutput("s2 out_pc",       outPc,    32'h4);
      checkOutput("s2 out_instr",    outInstr, 32'h1001);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("s3 out_pc",       outPc,    32'h8);
      checkOutput("s3 out_instr",    outInstr, 32'h1002);

      // Reset mid-stream with one entry buffered, then backpressure.
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("rst2 out_valid", 32'(outValid), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("bp0 imem_address", imemAddress, 32'h0);
      checkOutput("bp0 imem_valid",   32'(imemValid), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("bp1 out_pc",       outPc, 32'h0);
      checkOutput("bp1 imem_valid",   32'(imemValid), 32'h1);
      checkOutput("bp1 imem_address", imemAddress, 32'h4);
      for (int i = 2; i <= 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
         checkOutput($sformatf("bp%0d imem_valid", i), 32'(imemValid), 32'h0);
         checkOutput($sformatf("bp%0d imem_address", i), imemAddress, 32'h8);
         checkOutput($sformatf("bp%0d out_pc", i), outPc, 32'h0);
         checkOutput($sformatf("bp%0d out_instr", i), outInstr, 32'h1000);
      end

      // Full buffer released: pop and push in the same cycle.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rel0 out_pc",     outPc, 32'h0);
      checkOutput("rel0 imem_valid", 32'(imemValid), 32'h1);
      checkOutput("rel0 imem_addr",  imemAddress, 32'h8);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rel1 out_pc",     outPc, 32'h4);
      checkOutput("rel1 imem_addr",  imemAddress, 32'hC);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rel2 out_pc",     outPc, 32'h8);
      checkOutput("rel2 out_instr",  outInstr, 32'h1002);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rel3 out_pc",     outPc, 32'hC);

      // Redirect to an unaligned target while two entries are buffered.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h43);
      checkOutput("rd0 out_valid",  32'(outValid),  32'h0);
      checkOutput("rd0 imem_valid", 32'(imemValid), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rd1 imem_address", imemAddress, 32'h40);
      checkOutput("rd1 imem_valid",   32'(imemValid), 32'h1);
      checkOutput("rd1 out_valid",    32'(outValid),  32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rd2 out_valid", 32'(outValid), 32'h1);
      checkOutput("rd2 out_pc",    outPc,    32'h40);
      checkOutput("rd2 out_instr", outInstr, 32'h1010);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rd3 out_pc",    outPc,    32'h44);
      checkOutput("rd3 out_instr", outInstr, 32'h1011);

      // Fill to two entries, then reset mid-stream.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("fill out_pc", outPc, 32'h48);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("rst3 out_valid",  32'(outValid),  32'h0);
      checkOutput("rst3 imem_valid", 32'(imemValid), 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rs0 out_valid",    32'(outValid), 32'h0);
      checkOutput("rs0 imem_address", imemAddress,   32'h0);
      checkOutput("rs0 imem_valid",   32'(imemValid), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("rs1 out_pc",    outPc,    32'h0);
      checkOutput("rs1 out_instr", outInstr, 32'h1000);

      // PC wrap on the second instance.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      rstWrap = 1'b0;
      #1;
      checkOutput("w0 imem_address", wrapAddress, 32'hFFFF_FFFC);
      checkOutput("w0 imem_valid",   32'(wrapImemValid), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("w1 imem_address", wrapAddress, 32'h0);
      checkOutput("w1 out_pc",       wrapOutPc, 32'hFFFF_FFFC);
      checkOutput("w1 out_instr",    wrapOutInstr, 32'h4000_0FFF);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("w2 out_pc",       wrapOutPc, 32'h0);
      checkOutput("w2 out_instr",    wrapOutInstr, 32'h1000);
      checkOutput("w2 out_valid",    32'(wrapOutValid), 32'h1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-side initiator for the instruction memory. Holds the program counter, drives the memory's address/valid request, and captures the returned instruction word. It buffers fetched instructions in a small FIFO and hands them to decode over a valid/ready handshake. Control-flow redirects from execute flush the buffer and restart fetch at the new PC.

## Interface
- `Width`, default 32: address and instruction width.
- `ResetVector`, default 32'h0: PC loaded on reset.
- `Depth`, default 2: buffer entries, power of two, ≥2.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `imem_address`, out, Width: byte address of the fetch, equal to the current PC.
- `imem_valid`, out, 1: fetch request this cycle.
- `imem_data`, in, Width: instruction word. It is returned combinationally in the same cycle as `imem_valid`.
- `redirect_valid`, in, 1: flush and jump request.
- `redirect_pc`, in, Width: jump target. Bits [1:0] are ignored and forced to 0.
- `out_valid`, out, 1: buffered instruction available.
- `out_ready`, in, 1: decode accepts.
- `out_instr`, out, Width: instruction at the buffer head.
- `out_pc`, out, Width: PC of `out_instr`.

## Operation
- State:
  - `pc` register.
  - Buffer of Depth entries, each {pc, instr}.
  - Read pointer, write pointer and count, each sized $clog2(Depth)+1.
- Pop: happens when `out_valid && out_ready`. The head advances.
- Fetch enable: `imem_valid = !rst && !redirect_valid && (count < Depth || pop)`.
  - A push and a pop may happen in the same cycle while the buffer is full.
- On fetch:
  - Push {pc, imem_data}.
  - `pc <= pc + 4`, modulo 2^Width, so it wraps to 0 with no error.
- `imem_address` always equals `pc`. It is not gated by `imem_valid`.
- Redirect has priority over everything except reset:
  - `out_valid` is forced to 0 that cycle, and no pop is counted.
  - `imem_valid` is 0.
  - At the clock edge: count, pointers <= 0 and `pc <= {redirect_pc[Width-1:2], 2'b00}`.
- `out_valid = (count != 0) && !redirect_valid`.
- `out_instr` and `out_pc` come from the head entry. They are undefined when `out_valid` is 0.
- Reset:
  - `pc <= ResetVector`; count and pointers <= 0.
  - During the reset cycle, `out_valid` = 0 and `imem_valid` = 0.
  - Reset asserted mid-stream discards all buffered entries. No partial pop occurs.
- Buffer contents are not reset. Only the pointers and count are.

## Timing
- Outputs during and right after reset:
  - `imem_valid` = 0 and `out_valid` = 0 while reset is asserted.
  - `imem_address` = ResetVector in the first cycle after `rst` deasserts.
  - `imem_valid` = 1 in that same cycle.
- Fetch-to-decode latency is one cycle: an instruction fetched in cycle N is `out_valid` in cycle N+1.
- With `out_ready` held at 1, throughput is one instruction per cycle with no bubbles.
- Redirect costs one bubble:
  - Cycle R: redirect asserted, `out_valid` = 0.
  - Cycle R+1: fetch of the target.
  - Cycle R+2: target instruction becomes `out_valid`.
- Backpressure: while `out_valid && !out_ready`, `out_instr` and `out_pc` hold stable. Fetch continues until count == Depth, then stalls with `pc` held.
- Handshake rule: `out_valid` never drops without a pop, except on redirect or reset.

## Structure
- Package `fetch_pkg` holds:
  - `InstrBytes` = 4
  - `addr_t` / `instr_t` typedefs (logic [Width-1:0])
  - `fetch_entry_t` struct {addr_t pc; instr_t instr;}
- Sub-module `fetch_buffer` is a parameterised synchronous FIFO of `fetch_entry_t`. It has push/pop/flush, count, and full/empty outputs.
- The PC register and the fetch-enable logic live in `instruction_fetch`.

## Test plan
- Reset release, `out_ready`=1, memory word[i] = 0x1000+i:
  - `imem_address` runs 0x0, 0x4, 0x8…
  - Decode receives (pc 0x0, 0x1000), (0x4, 0x1001), (0x8, 0x1002) on consecutive cycles starting one cycle after reset.
- Backpressure with `out_ready`=0 for 5 cycles after the first fetch:
  - `out_pc` stays 0x0.
  - Exactly 2 fetches occur (0x0, 0x4), then `imem_valid`=0 with `pc` at 0x8.
  - Releasing `out_ready` yields 0x0, 0x4, 0x8 without loss or duplication.
- Full buffer with `out_ready` toggled to 1: a pop and a push occur in the same cycle and count stays 2.
- Redirect to 0x43 while the buffer holds 2 entries:
  - `out_valid` = 0 that cycle.
  - Next cycle `imem_address` = 0x40.
  - Next decoded pair is (0x40, word[16]); no stale entries appear.
- Reset asserted mid-stream with count = 2: the next cycle has `out_valid` = 0, then fetch restarts at ResetVector.
- PC wrap with ResetVector = 0xFFFFFFFC: fetches 0xFFFFFFFC then 0x00000000, and `out_pc` values match.
